// File: rtl/stage_wb_if.sv
// MEM/WB stage bus: memory-stage results and pipeline control in,
// register-file write port and status out.
interface stage_wb_if #(
  parameter int COUNT_WIDTH = 32
);
  logic                   stall;
  logic                   flush;
  logic                   inValid;
  logic                   inRegWrite;
  logic [1:0]             inMemtoReg;
  logic [2:0]             inflagLoadWordDividerMEM;
  logic [4:0]             inWriteReg;
  logic [31:0]            inAluResult;
  logic [31:0]            inMemData;
  logic [31:0]            inLinkPc;
  logic                   outRegWrite;
  logic [4:0]             outWriteReg;
  logic [31:0]            outWriteData;
  logic                   outValid;
  logic                   excLoadMisaligned;
  logic [COUNT_WIDTH-1:0] retireCount;

  modport master (
    output stall, flush, inValid, inRegWrite, inMemtoReg,
           inflagLoadWordDividerMEM, inWriteReg, inAluResult, inMemData, inLinkPc,
    input  outRegWrite, outWriteReg, outWriteData, outValid,
           excLoadMisaligned, retireCount
  );

  modport slave (
    input  stall, flush, inValid, inRegWrite, inMemtoReg,
           inflagLoadWordDividerMEM, inWriteReg, inAluResult, inMemData, inLinkPc,
    output outRegWrite, outWriteReg, outWriteData, outValid,
           excLoadMisaligned, retireCount
  );
endinterface

// File: rtl/stage_wb.sv
// MEM/WB pipeline stage: latches memory results, extracts sub-word loads,
// selects the write-back value and drives the register-file write port.
module stage_wb #(
  parameter int COUNT_WIDTH = 32,
  parameter bit BIG_ENDIAN  = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  stage_wb_if.slave bus
);
  localparam logic [COUNT_WIDTH-1:0] CountOne = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic                   validR;
  logic                   regWriteR;
  logic [1:0]             memtoRegR;
  logic [2:0]             dividerR;
  logic [4:0]             writeRegR;
  logic [31:0]            aluResultR;
  logic [31:0]            memDataR;
  logic [31:0]            linkPcR;
  logic [COUNT_WIDTH-1:0] countR;

  logic [1:0]  off;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadData;
  logic [31:0] writeData;
  logic        alignFault;
  logic        misaligned;

  assign off = aluResultR[1:0];

  // MEM/WB latch and retire counter: flush beats stall beats capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validR     <= 1'b0;
      regWriteR  <= 1'b0;
      memtoRegR  <= 2'd0;
      dividerR   <= 3'd0;
      writeRegR  <= 5'd0;
      aluResultR <= 32'd0;
      memDataR   <= 32'd0;
      linkPcR    <= 32'd0;
      countR     <= {COUNT_WIDTH{1'b0}};
    end else if (bus.flush) begin
      validR     <= 1'b0;
      regWriteR  <= 1'b0;
      memtoRegR  <= 2'd0;
      dividerR   <= 3'd0;
      writeRegR  <= 5'd0;
      aluResultR <= 32'd0;
      memDataR   <= 32'd0;
      linkPcR    <= 32'd0;
    end else if (!bus.stall) begin
      validR     <= bus.inValid;
      regWriteR  <= bus.inRegWrite;
      memtoRegR  <= bus.inMemtoReg;
      dividerR   <= bus.inflagLoadWordDividerMEM;
      writeRegR  <= bus.inWriteReg;
      aluResultR <= bus.inAluResult;
      memDataR   <= bus.inMemData;
      linkPcR    <= bus.inLinkPc;
      if (bus.inValid) begin
        countR <= countR + CountOne;
      end
    end
  end

  // Byte and halfword lane selection; lane 0 sits in the MSBs when big-endian.
  always_comb begin
    byteSel = 8'd0;
    case (off)
      2'd0:    byteSel = BIG_ENDIAN ? memDataR[31:24] : memDataR[7:0];
      2'd1:    byteSel = BIG_ENDIAN ? memDataR[23:16] : memDataR[15:8];
      2'd2:    byteSel = BIG_ENDIAN ? memDataR[15:8]  : memDataR[23:16];
      2'd3:    byteSel = BIG_ENDIAN ? memDataR[7:0]   : memDataR[31:24];
      default: byteSel = 8'd0;
    endcase
    if (off[1] ^ BIG_ENDIAN) begin
      halfSel = memDataR[31:16];
    end else begin
      halfSel = memDataR[15:0];
    end
  end

  // Load extension and alignment check; unused divider codes behave as lw.
  always_comb begin
    loadData   = memDataR;
    alignFault = 1'b0;
    case (dividerR)
      3'b001: begin
        loadData   = {{16{halfSel[15]}}, halfSel};
        alignFault = off[0];
      end
      3'b010: begin
        loadData   = {16'd0, halfSel};
        alignFault = off[0];
      end
      3'b011: begin
        loadData   = {{24{byteSel[7]}}, byteSel};
        alignFault = 1'b0;
      end
      3'b100: begin
        loadData   = {24'd0, byteSel};
        alignFault = 1'b0;
      end
      default: begin
        loadData   = memDataR;
        alignFault = (off != 2'd0);
      end
    endcase
  end

  // Write-back source select.
  always_comb begin
    writeData = aluResultR;
    case (memtoRegR)
      2'b00:   writeData = aluResultR;
      2'b01:   writeData = loadData;
      2'b10:   writeData = linkPcR;
      default: writeData = aluResultR;
    endcase
  end

  assign misaligned = validR & (memtoRegR == 2'b01) & alignFault;

  assign bus.outRegWrite       = validR & regWriteR & (writeRegR != 5'd0) & ~misaligned;
  assign bus.outWriteReg       = writeRegR;
  assign bus.outWriteData      = writeData;
  assign bus.outValid          = validR;
  assign bus.excLoadMisaligned = misaligned;
  assign bus.retireCount       = countR;
endmodule

// File: tb/tb_stage_wb.sv
// Self-checking bench for stage_wb: directed cases from the stage's rules plus
// randomized traffic against a behavioural model of the MEM/WB latch.
module tb_stage_wb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  stage_wb_if #(.COUNT_WIDTH(4)) bus();
  stage_wb #(.COUNT_WIDTH(4), .BIG_ENDIAN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference model of the latched entry
  logic        mValid, mRw;
  logic [1:0]  mM2r;
  logic [2:0]  mDiv;
  logic [4:0]  mWr;
  logic [31:0] mAlu, mMem, mLink;
  int          mCnt;

  task automatic modelReset();
    mValid = 0; mRw = 0; mM2r = 0; mDiv = 0; mWr = 0;
    mAlu = 0; mMem = 0; mLink = 0; mCnt = 0;
  endtask

  function automatic logic [31:0] expLoad();
    int unsigned off = mAlu % 4;
    int unsigned b = (mMem >> (8 * (3 - off))) % 256;
    int unsigned h = (off >= 2) ? (mMem % 65536) : (mMem / 65536);
    case (mDiv)
      3'd1:    return (h >= 32768) ? 32'(h + 32'hFFFF0000) : 32'(h);
      3'd2:    return 32'(h);
      3'd3:    return (b >= 128) ? 32'(b + 32'hFFFFFF00) : 32'(b);
      3'd4:    return 32'(b);
      default: return mMem;
    endcase
  endfunction

  function automatic logic [31:0] expData();
    if (mM2r == 2'd1) return expLoad();
    if (mM2r == 2'd2) return mLink;
    return mAlu;
  endfunction

  function automatic logic expMis();
    int unsigned off = mAlu % 4;
    if (!mValid || mM2r != 2'd1) return 1'b0;
    if (mDiv == 3'd1 || mDiv == 3'd2) return (off % 2) != 0;
    if (mDiv == 3'd3 || mDiv == 3'd4) return 1'b0;
    return off != 0;
  endfunction

  function automatic logic expRw();
    return mValid && mRw && (mWr != 0) && !expMis();
  endfunction

  task automatic step(input logic v, input logic rw, input logic [1:0] m2r,
                      input logic [2:0] div, input logic [4:0] wr,
                      input logic [31:0] alu, input logic [31:0] mem,
                      input logic [31:0] link, input logic st, input logic fl);
    bus.inValid = v; bus.inRegWrite = rw; bus.inMemtoReg = m2r;
    bus.inflagLoadWordDividerMEM = div; bus.inWriteReg = wr;
    bus.inAluResult = alu; bus.inMemData = mem; bus.inLinkPc = link;
    bus.stall = st; bus.flush = fl;
    @(posedge clk);
    if (fl) begin
      mValid = 0; mRw = 0; mM2r = 0; mDiv = 0; mWr = 0; mAlu = 0; mMem = 0; mLink = 0;
    end else if (!st) begin
      mValid = v; mRw = rw; mM2r = m2r; mDiv = div; mWr = wr;
      mAlu = alu; mMem = mem; mLink = link;
      if (v) mCnt = (mCnt + 1) % 16;
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.outRegWrite !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b exp 0", bus.outRegWrite); end
    checks++; if (bus.outWriteReg !== 5'd0) begin errors++; $display("FAIL reset_wr: got %0d exp 0", bus.outWriteReg); end
    checks++; if (bus.outWriteData !== 32'd0) begin errors++; $display("FAIL reset_data: got %h exp 0", bus.outWriteData); end
    checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bus.outValid); end
    checks++; if (bus.excLoadMisaligned !== 1'b0) begin errors++; $display("FAIL reset_exc: got %b exp 0", bus.excLoadMisaligned); end
    checks++; if (bus.retireCount !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", bus.retireCount); end
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic test_lw();
    step(1, 1, 2'd1, 3'd0, 5'd5, 32'h100, 32'h80FF7F01, 32'd0, 0, 0);
    checks++; if (bus.outRegWrite !== 1'b1) begin errors++; $display("FAIL lw_rw: got %b exp 1", bus.outRegWrite); end
    checks++; if (bus.outWriteReg !== 5'd5) begin errors++; $display("FAIL lw_wr: got %0d exp 5", bus.outWriteReg); end
    checks++; if (bus.outWriteData !== 32'h80FF7F01) begin errors++; $display("FAIL lw_data: got %h exp 80ff7f01", bus.outWriteData); end
    checks++; if (bus.retireCount !== 4'd1) begin errors++; $display("FAIL lw_cnt: got %0d exp 1", bus.retireCount); end
  endtask

  task automatic test_subword();
    logic [2:0]  divs [4] = '{3'd3, 3'd4, 3'd1, 3'd1};
    logic [31:0] addrs[4] = '{32'h101, 32'h103, 32'h102, 32'h100};
    logic [31:0] exps [4] = '{32'hFFFFFFFF, 32'h00000001, 32'h00007F01, 32'hFFFF80FF};
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 2'd1, divs[i], 5'd6, addrs[i], 32'h80FF7F01, 32'd0, 0, 0);
      checks++; if (bus.outWriteData !== exps[i]) begin errors++; $display("FAIL subword_data[%0d]: got %h exp %h", i, bus.outWriteData, exps[i]); end
      checks++; if (bus.outRegWrite !== 1'b1 || bus.excLoadMisaligned !== 1'b0) begin errors++; $display("FAIL subword_ctl[%0d]: got rw=%b exc=%b exp rw=1 exc=0", i, bus.outRegWrite, bus.excLoadMisaligned); end
    end
  endtask

  task automatic test_misaligned();
    step(1, 1, 2'd1, 3'd0, 5'd9, 32'h102, 32'h80FF7F01, 32'd0, 0, 0);
    checks++; if (bus.excLoadMisaligned !== 1'b1) begin errors++; $display("FAIL mis_exc: got %b exp 1", bus.excLoadMisaligned); end
    checks++; if (bus.outRegWrite !== 1'b0) begin errors++; $display("FAIL mis_rw: got %b exp 0", bus.outRegWrite); end
    checks++; if (bus.retireCount !== 4'd6) begin errors++; $display("FAIL mis_cnt: got %0d exp 6", bus.retireCount); end
    step(1, 1, 2'd0, 3'd0, 5'd0, 32'h1234, 32'd0, 32'd0, 0, 0);
    checks++; if (bus.outRegWrite !== 1'b0) begin errors++; $display("FAIL r0_rw: got %b exp 0", bus.outRegWrite); end
    checks++; if (bus.outWriteData !== 32'h1234 || bus.outWriteReg !== 5'd0) begin errors++; $display("FAIL r0_data: got %h/%0d exp 1234/0", bus.outWriteData, bus.outWriteReg); end
  endtask

  task automatic test_stall_flush();
    logic [3:0] c0;
    step(1, 1, 2'd2, 3'd0, 5'd31, 32'h55, 32'h66, 32'h408, 0, 0);
    c0 = 4'(mCnt);
    checks++; if (bus.outWriteData !== 32'h408 || bus.outWriteReg !== 5'd31 || bus.outRegWrite !== 1'b1) begin errors++; $display("FAIL jal: got %h/%0d/%b exp 408/31/1", bus.outWriteData, bus.outWriteReg, bus.outRegWrite); end
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 2'd0, 3'd0, 5'(i + 2), $urandom, $urandom, $urandom, 1, 0);
      checks++; if (bus.outWriteData !== 32'h408 || bus.outWriteReg !== 5'd31 || bus.outValid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got %h/%0d/%b exp 408/31/1", i, bus.outWriteData, bus.outWriteReg, bus.outValid); end
      checks++; if (bus.retireCount !== c0) begin errors++; $display("FAIL stall_cnt[%0d]: got %0d exp %0d", i, bus.retireCount, c0); end
    end
    step(1, 1, 2'd0, 3'd0, 5'd3, 32'h77, 32'd0, 32'd0, 1, 1);
    checks++; if (bus.outValid !== 1'b0 || bus.outRegWrite !== 1'b0) begin errors++; $display("FAIL flush: got valid=%b rw=%b exp 0/0", bus.outValid, bus.outRegWrite); end
    checks++; if (bus.retireCount !== c0) begin errors++; $display("FAIL flush_cnt: got %0d exp %0d", bus.retireCount, c0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom_range(0, 7)),
           5'($urandom), $urandom, $urandom, $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      checks++; if (bus.outWriteData !== expData()) begin errors++; $display("FAIL rand_data[%0d]: got %h exp %h", i, bus.outWriteData, expData()); end
      checks++; if (bus.outRegWrite !== expRw()) begin errors++; $display("FAIL rand_rw[%0d]: got %b exp %b", i, bus.outRegWrite, expRw()); end
      checks++; if (bus.excLoadMisaligned !== expMis()) begin errors++; $display("FAIL rand_exc[%0d]: got %b exp %b", i, bus.excLoadMisaligned, expMis()); end
      checks++; if (bus.outWriteReg !== mWr || bus.outValid !== mValid) begin errors++; $display("FAIL rand_reg[%0d]: got %0d/%b exp %0d/%b", i, bus.outWriteReg, bus.outValid, mWr, mValid); end
      checks++; if (bus.retireCount !== 4'(mCnt)) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d exp %0d", i, bus.retireCount, mCnt); end
    end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    modelReset();
    for (int i = 0; i < 17; i++) step(1, 0, 2'd0, 3'd0, 5'd1, $urandom, 32'd0, 32'd0, 0, 0);
    checks++; if (bus.retireCount !== 4'd1) begin errors++; $display("FAIL wrap_cnt: got %0d exp 1", bus.retireCount); end
  endtask

  task automatic test_async_reset();
    step(1, 1, 2'd0, 3'd0, 5'd7, 32'hDEADBEEF, 32'd0, 32'd0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.outRegWrite !== 1'b0 || bus.outValid !== 1'b0) begin errors++; $display("FAIL async_ctl: got rw=%b valid=%b exp 0/0", bus.outRegWrite, bus.outValid); end
    checks++; if (bus.outWriteData !== 32'd0 || bus.outWriteReg !== 5'd0) begin errors++; $display("FAIL async_data: got %h/%0d exp 0/0", bus.outWriteData, bus.outWriteReg); end
    checks++; if (bus.retireCount !== 4'd0) begin errors++; $display("FAIL async_cnt: got %0d exp 0", bus.retireCount); end
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    modelReset();
    test_reset();
    test_lw();
    test_subword();
    test_misaligned();
    test_stall_flush();
    test_random();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_wb.md
Name: stage_wb

Overview:
- MEM/WB pipeline stage: latches memory-stage results on each clock.
- Extracts and extends sub-word load data according to the load-divider flag, then selects the write-back value.
- Drives the register-file write port consumed by the decode stage: write enable, write register and write data.
- Also counts retired instructions and flags misaligned loads.

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter.
- BIG_ENDIAN, 1, byte lane order. 1 means byte offset 0 is bits [31:24]; 0 means byte offset 0 is bits [7:0].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- stall  in  1  hold the MEM/WB latch contents.
- flush  in  1  load a bubble into the latch.
- inValid  in  1  MEM stage holds a real instruction.
- inRegWrite  in  1  instruction writes a register.
- inMemtoReg  in  2  write-back source select.
- inflagLoadWordDividerMEM  in  3  load size/sign select.
- inWriteReg  in  5  destination register.
- inAluResult  in  32  ALU result; also the load address.
- inMemData  in  32  raw 32-bit word read from data memory.
- inLinkPc  in  32  return address for jump-and-link.
- outRegWrite  out  1  register-file write enable.
- outWriteReg  out  5  register-file write address.
- outWriteData  out  32  register-file write data.
- outValid  out  1  latched entry is a real instruction.
- excLoadMisaligned  out  1  latched load is misaligned; write suppressed.
- retireCount  out  COUNT_WIDTH  count of retired valid instructions.

Behaviour:
- Reset (rst_n low, asynchronous): every latch field and retireCount clear to 0.
  - Consequently outRegWrite=0, outWriteReg=0, outWriteData=0, outValid=0, excLoadMisaligned=0.
  - Reset asserted mid-operation discards the latched instruction immediately.
- Latch update priority per edge: flush > stall > load.
  - flush: bubble; valid=0, regwrite=0, other fields 0.
  - stall (without flush): all fields hold.
  - Otherwise all in* signals are captured.
- Latency: inputs captured at edge N drive the outputs combinationally from the latch during cycle N+1. The decode stage register file writes at edge N+1.
- Load extraction (divider encoding), using off = latched inAluResult[1:0]:
  - 000 lw: full word.
  - 001 lh: halfword at off[1], sign-extended.
  - 010 lhu: halfword at off[1], zero-extended.
  - 011 lb: byte at off, sign-extended.
  - 100 lbu: byte at off, zero-extended.
  - 101-111: treated as lw.
- Halfword lanes with BIG_ENDIAN=1: off[1]=0 selects [31:16]; off[1]=1 selects [15:0].
- Write-back select (inMemtoReg):
  - 00: ALU result.
  - 01: extracted load data.
  - 10: inLinkPc.
  - 11: ALU result (reserved).
- Misalignment is checked only when MemtoReg=01:
  - lw with off!=0, or lh/lhu with off[0]=1, is misaligned.
  - excLoadMisaligned=1 for the cycle the entry is latched (held while stalled).
  - outRegWrite is forced to 0 for that entry.
- outRegWrite = latched valid & latched regwrite & (writeReg!=0) & ~misaligned. Writes to $0 are never issued.
- outWriteReg and outWriteData always reflect the latch, even when outRegWrite=0.
- retireCount increments by 1 on each edge where a valid entry is newly captured (not flush, not stall, inValid=1).
  - A stalled entry is counted once.
  - The counter wraps from all-ones to 0 with no flag.
- Simultaneous flush and stall: flush wins; the counter does not increment.

Test Plan:
- Reset then lw: rst_n low then high; inMemData=0x80FF7F01, divider=000, MemtoReg=01, addr=0x100, writeReg=5 -> next cycle outRegWrite=1, outWriteReg=5, outWriteData=0x80FF7F01, retireCount=1.
- Sub-word loads on the same word, BIG_ENDIAN=1:
  - lb addr 0x101 -> 0xFFFFFFFF.
  - lbu addr 0x103 -> 0x00000001.
  - lh addr 0x102 -> 0x00007F01.
  - lh addr 0x100 -> 0xFFFF80FF.
- Misaligned and $0: lw at addr 0x102 -> excLoadMisaligned=1, outRegWrite=0, retireCount still increments. ALU write to reg 0 with data 0x1234 -> outRegWrite=0.
- Stall/flush: capture jal (MemtoReg=10, inLinkPc=0x408, reg 31), then hold stall 3 cycles -> outputs hold and retireCount +1 only. Assert flush+stall together -> outValid=0, outRegWrite=0, count unchanged.
- Counter wrap and async reset: with COUNT_WIDTH=4, 17 valid captures -> retireCount=1. Drop rst_n between edges -> outputs go to 0 immediately, without waiting for a clock edge.
